ps2iec_demux: RTL

PS2IEC_DEMUX -- requirements
Module: ps2iec_demux

---
 rtl/ps2iec_demux_if.sv | 30 +++
 rtl/ps2iec_demux.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ps2iec_demux_if.sv
// ps2iec_demux_if: shared PS/2 + IEC mux bus and the demultiplexed line outputs.
// The slave modport is the demultiplexer; the master modport is the board side
// that drives the external bus and observes the demultiplexed lines.
interface ps2iec_demux_if;
  logic [3:0] ps2iec;
  logic       ps2iec_sel;
  logic       sample_stb;
  logic       ps2_mouse_clk;
  logic       ps2_mouse_dat;
  logic       ps2_keyboard_clk;
  logic       ps2_keyboard_dat;
  logic       iec_atn;
  logic       iec_clk;
  logic       iec_dat;
  logic       iec_srq;

  modport master (
    output ps2iec,
    input  ps2iec_sel, sample_stb,
    input  ps2_mouse_clk, ps2_mouse_dat, ps2_keyboard_clk, ps2_keyboard_dat,
    input  iec_atn, iec_clk, iec_dat, iec_srq
  );

  modport slave (
    input  ps2iec,
    output ps2iec_sel, sample_stb,
    output ps2_mouse_clk, ps2_mouse_dat, ps2_keyboard_clk, ps2_keyboard_dat,
    output iec_atn, iec_clk, iec_dat, iec_srq
  );
endinterface

// File: rtl/ps2iec_demux.sv
// ps2iec_demux: demultiplexes a 4-bit time-shared bus into four PS/2 lines and
// four IEC lines. The select alternates every SETTLE_CYCLES+1 clocks; the bus
// is sampled on the last count of each phase, giving the external mux time to
// settle after the select change.
// Optional feature macro: PS2IEC_FILTER_EN -- an output bit only updates when
// two consecutive samples of its own phase agree.
module ps2iec_demux #(
  parameter int unsigned SETTLE_CYCLES = 15
) (
  input  logic          clk,
  input  logic          n_reset,
  ps2iec_demux_if.slave bus
);

  typedef enum logic {
    PH_IEC = 1'b0,
    PH_PS2 = 1'b1
  } phase_t;

  localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES);
  localparam logic [7:0] PRE_CNT  = 8'(SETTLE_CYCLES - 1);

  logic [3:0] sync0_r;
  logic [3:0] sync1_r;
  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;
  phase_t     phase_r;
  phase_t     phase_nxt_s;
  logic       stb_r;
  logic       stb_nxt_s;
  logic [3:0] ps2_r;
  logic [3:0] ps2_nxt_s;
  logic [3:0] iec_r;
  logic [3:0] iec_nxt_s;

`ifdef PS2IEC_FILTER_EN
  logic [3:0] ps2_prev_r;
  logic [3:0] ps2_prev_nxt_s;
  logic [3:0] iec_prev_r;
  logic [3:0] iec_prev_nxt_s;

  // Bits where the new sample matches the previous one take the sample,
  // disagreeing bits keep their current output value.
  function automatic logic [3:0] agree_merge(input logic [3:0] cur,
                                             input logic [3:0] smp,
                                             input logic [3:0] prev);
    logic [3:0] agree;
    agree = ~(smp ^ prev);
    return (smp & agree) | (cur & ~agree);
  endfunction
`endif

  // Two-flop synchronizer; the external bus is asynchronous to clk.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync0_r <= 4'hF;
      sync1_r <= 4'hF;
    end else begin
      sync0_r <= bus.ps2iec;
      sync1_r <= sync0_r;
    end
  end

  // Next-state logic: phase counter, select toggle, strobe and group capture.
  always_comb begin
    cnt_nxt_s   = cnt_r + 8'd1;
    phase_nxt_s = phase_r;
    stb_nxt_s   = (cnt_r == PRE_CNT);
    ps2_nxt_s   = ps2_r;
    iec_nxt_s   = iec_r;
`ifdef PS2IEC_FILTER_EN
    ps2_prev_nxt_s = ps2_prev_r;
    iec_prev_nxt_s = iec_prev_r;
`endif
    if (cnt_r == LAST_CNT) begin
      cnt_nxt_s = 8'd0;
      case (phase_r)
        PH_PS2: begin
          phase_nxt_s = PH_IEC;
`ifdef PS2IEC_FILTER_EN
          ps2_nxt_s      = agree_merge(ps2_r, sync1_r, ps2_prev_r);
          ps2_prev_nxt_s = sync1_r;
`else
          ps2_nxt_s = sync1_r;
`endif
        end
        PH_IEC: begin
          phase_nxt_s = PH_PS2;
`ifdef PS2IEC_FILTER_EN
          iec_nxt_s      = agree_merge(iec_r, sync1_r, iec_prev_r);
          iec_prev_nxt_s = sync1_r;
`else
          iec_nxt_s = sync1_r;
`endif
        end
        default: begin
          phase_nxt_s = PH_IEC;
        end
      endcase
    end else begin
      cnt_nxt_s = cnt_r + 8'd1;
    end
  end

  // State register: counter, phase (drives the select directly), strobe, outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_r   <= 8'd0;
      phase_r <= PH_IEC;
      stb_r   <= 1'b0;
      ps2_r   <= 4'hF;
      iec_r   <= 4'hF;
    end else begin
      cnt_r   <= cnt_nxt_s;
      phase_r <= phase_nxt_s;
      stb_r   <= stb_nxt_s;
      ps2_r   <= ps2_nxt_s;
      iec_r   <= iec_nxt_s;
    end
  end

`ifdef PS2IEC_FILTER_EN
  // Previous-sample history for the agreement filter, one word per group.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ps2_prev_r <= 4'hF;
      iec_prev_r <= 4'hF;
    end else begin
      ps2_prev_r <= ps2_prev_nxt_s;
      iec_prev_r <= iec_prev_nxt_s;
    end
  end
`endif

  assign bus.ps2iec_sel       = phase_r;
  assign bus.sample_stb       = stb_r;
  assign bus.ps2_mouse_clk    = ps2_r[0];
  assign bus.ps2_mouse_dat    = ps2_r[1];
  assign bus.ps2_keyboard_clk = ps2_r[2];
  assign bus.ps2_keyboard_dat = ps2_r[3];
  assign bus.iec_atn          = iec_r[0];
  assign bus.iec_clk          = iec_r[1];
  assign bus.iec_dat          = iec_r[2];
  assign bus.iec_srq          = iec_r[3];

endmodule
